// File: rtl/mem_access_ctrl_if.sv
// Request, response and data-memory port bundle for the load/store controller.
// slave = controller side, master = CPU/memory environment side.
interface mem_access_ctrl_if #(
  parameter int unsigned BITS = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_signed;
  logic [31:0]     req_addr;
  logic [BITS-1:0] req_wdata;

  logic            resp_valid;
  logic            resp_ready;
  logic [BITS-1:0] resp_rdata;
  logic            resp_err;

  logic            mem_rw_;
  logic [31:0]     mem_addr;
  logic [BITS-1:0] mem_wdata;
  logic [3:0]      mem_byte_en;
  logic [BITS-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_rw_, mem_addr, mem_wdata, mem_byte_en
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_rw_, mem_addr, mem_wdata, mem_byte_en
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store controller: legal request -> response 2 cycles after accept, error -> 1 cycle.
// Response is held until resp_ready; req_ready is low outside IDLE, so requests stall while a response waits.
`ifndef MEM_NUM_BITS_DEF
`define MEM_NUM_BITS_DEF 32
`endif
`ifndef MEM_NUM_WORDS_DEF
`define MEM_NUM_WORDS_DEF 1024
`endif
`ifndef MEM_BASE_ADDR_DEF
`define MEM_BASE_ADDR_DEF 32'h0000_0000
`endif

module mem_access_ctrl #(
  parameter int unsigned BITS      = `MEM_NUM_BITS_DEF,
  parameter int unsigned WORDS     = `MEM_NUM_WORDS_DEF,
  parameter logic [31:0] BASE_ADDR = `MEM_BASE_ADDR_DEF
) (
  input logic              clk,
  input logic              rst,
  mem_access_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic            we;
    logic [1:0]      size;
    logic            sgn;
    logic [31:0]     addr;
    logic [BITS-1:0] wdata;
  } req_t;

  logic [1:0]      state;
  req_t            lat;
  logic [BITS-1:0] rdata_q;
  logic            err_q;

  logic [32:0]     addr_ext;
  logic [32:0]     lo_bound;
  logic [32:0]     hi_bound;
  logic            legal;
  logic [3:0]      be_dec;
  logic [BITS-1:0] load_ext;

  // 33-bit bounds so BASE_ADDR+WORDS cannot wrap past 2^32.
  assign addr_ext = {1'b0, bus.req_addr};
  assign lo_bound = {1'b0, BASE_ADDR};
  assign hi_bound = lo_bound + 33'(WORDS);
  assign legal    = (bus.req_size != 2'b11) && (addr_ext >= lo_bound) && (addr_ext < hi_bound);

  always_comb begin
    be_dec   = 4'b0000;
    load_ext = bus.mem_rdata;
    case (lat.size)
      SZ_BYTE: begin
        be_dec   = 4'b0001;
        load_ext = {{(BITS-8){lat.sgn & bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
      end
      SZ_HALF: begin
        be_dec   = 4'b0011;
        load_ext = {{(BITS-16){lat.sgn & bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
      end
      SZ_WORD: be_dec = 4'b1111;
      default: be_dec = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      lat     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            lat.we    <= bus.req_we;
            lat.size  <= bus.req_size;
            lat.sgn   <= bus.req_signed;
            lat.addr  <= bus.req_addr;
            lat.wdata <= bus.req_wdata;
            if (legal) begin
              state <= S_ACCESS;
            end else begin
              state   <= S_RESP;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end
          end
        end
        S_ACCESS: begin
          err_q   <= 1'b0;
          rdata_q <= lat.we ? '0 : load_ext;
          state   <= S_RESP;
        end
        S_RESP: begin
          if (bus.resp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (state == S_IDLE);
  assign bus.resp_valid  = (state == S_RESP);
  assign bus.resp_rdata  = rdata_q;
  assign bus.resp_err    = err_q;
  assign bus.mem_addr    = lat.addr;
  assign bus.mem_wdata   = lat.wdata;
  assign bus.mem_byte_en = (state == S_ACCESS) ? be_dec : 4'b0000;
  // A reset cycle must never present a write strobe to memory.
  assign bus.mem_rw_     = rst | ~((state == S_ACCESS) & lat.we);

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Initiator-side load/store controller for the word-addressed data memory. It accepts one CPU load or store request at a time through a valid/ready handshake and translates byte, half and word sizes into the memory's `rw_`/`byte_en` encoding. It range-checks the address, sign- or zero-extends load data, and returns a registered response with an error flag. It sits between the CPU execute/memory stage and the data memory port.

## Interface
- `BITS`, `` `MEM_NUM_BITS_DEF `` (32): data width.
- `WORDS`, `` `MEM_NUM_WORDS_DEF ``: memory depth in words, used for the range check.
- `BASE_ADDR`, `` `MEM_BASE_ADDR_DEF ``: first valid word address.

One clock; reset is synchronous and active-high.

- `clk` in 1: system clock; all state changes on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_signed` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `req_addr` in 32: word address.
- `req_wdata` in BITS: store data; low lanes are used for byte and half.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer takes the response.
- `resp_rdata` out BITS: extended load data; 0 for stores and errors.
- `resp_err` out 1: illegal size or out-of-range address.
- `mem_rw_` out 1: memory read = 1, write = 0.
- `mem_addr` out 32: memory word address.
- `mem_wdata` out BITS: memory write data.
- `mem_byte_en` out 4: memory byte enables.
- `mem_rdata` in BITS: combinational read data from memory.

## Operation
- **FSM states:** IDLE, ACCESS, RESP.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch we, size, signed, addr and wdata.
  - Evaluate legality: size != 11 and BASE_ADDR <= addr < BASE_ADDR+WORDS, computed 33-bit, no wrap.
  - Legal → ACCESS.
  - Illegal → RESP with `resp_err`=1, `resp_rdata`=0, and no memory access.
- **ACCESS (exactly one cycle):**
  - `mem_addr`=latched addr.
  - `mem_byte_en` = 0001, 0011 or 1111 for byte, half or word.
  - Store:
    - `mem_rw_`=0 and `mem_wdata`=latched wdata; the memory writes on the posedge ending ACCESS.
    - `resp_rdata`←0.
  - Load:
    - `mem_rw_`=1.
    - At the posedge ending ACCESS, `resp_rdata` is loaded from `mem_rdata`:
      - byte: [7:0] extended from bit 7;
      - half: [15:0] extended from bit 15;
      - word: unchanged.
  - `resp_err`←0, then → RESP.
- **RESP:**
  - `resp_valid`=1.
  - `resp_rdata`/`resp_err` are held stable until `resp_valid`&&`resp_ready`, then → IDLE.
  - `req_valid` is ignored here.
- **Memory-side defaults outside ACCESS:** `mem_rw_`=1, `mem_byte_en`=0000, `mem_addr`/`mem_wdata` hold their last latched values.
- **Write safety:** `mem_rw_` is forced to 1 combinationally whenever `rst`=1, so no write occurs in a reset cycle.

## Timing
- **Reset values:**
  - state=IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0;
  - `mem_rw_`=1, `mem_addr`=0, `mem_wdata`=0, `mem_byte_en`=0000.
- **Legal-request latency:** accept at edge N; ACCESS during cycle N+1; `resp_valid` high in cycle N+2.
- **Error latency:** accept at edge N; `resp_valid`/`resp_err` high in cycle N+1.
- **Throughput:** one legal request per 3 cycles minimum. `resp_ready` held high ends RESP after one cycle, and IDLE re-accepts in the following cycle.
- **Reset mid-operation:**
  - `rst` in any state returns to IDLE at the next edge and drops `resp_valid`; the pending response is discarded.
  - `rst` during a store ACCESS suppresses the write.
- **Response output timing:** `resp_rdata` and `resp_err` are registered. `req_ready` and the `mem_*` strobes are decoded from state and latched registers, with no combinational path from `req_*` inputs.

## Test plan
- **Reset:** assert `rst` 2 cycles → `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `mem_rw_`=1, `mem_byte_en`=0000.
- **Word store then load:**
  - Store word 0xDEADBEEF at BASE_ADDR+3 → `mem_rw_`=0 for exactly one cycle with `mem_byte_en`=1111; response at N+2 with `resp_err`=0.
  - Then load word from BASE_ADDR+3 → `resp_rdata`=0xDEADBEEF.
- **Sub-word extension** (word 0x12348001 preloaded at BASE_ADDR):
  - Store byte 0xFF_F0 → `byte_en`=0001.
  - Signed byte load → 0xFFFFFFF0; unsigned byte load → 0x000000F0.
  - Signed half load → 0xFFFF80F0; word load → 0x123480F0.
- **Errors:**
  - Store at BASE_ADDR+WORDS, and at BASE_ADDR-1 → `resp_err`=1 at N+1, `mem_rw_` never 0.
  - `req_size`=11 load → `resp_err`=1, `resp_rdata`=0.
- **Backpressure:** hold `resp_ready`=0 for 5 cycles during RESP while pulsing `req_valid` → `resp_valid` and `resp_rdata` stable, `req_ready`=0, no new memory access. Release → IDLE next cycle.
- **Reset during store ACCESS:** assert `rst` in the store's ACCESS cycle → `mem_rw_` stays 1, memory word unchanged on readback, `resp_valid`=0, state IDLE.
